neo_pvc_gen2: RTL and testbench
===============================

Name: neo_pvc_gen2

Overview:
- Parametrised, fully synchronous NEO-PVC-class cartridge protection and banking controller for the P2 ROM region (0x200000–0x2FFFFF).
- Sits between the 68K port bus and the P2 PROM.
- Provides up to 4 switchable P2 banks, on-chip work RAM with a hardware clear sequencer after reset, and colour pack/unpack ports.
- All CPU strobes are sampled on CLK_24M; no logic is clocked on strobe edges.

Parameters:
- RAM_AW, 12: RAM word-address width; RAM occupies the top 2^(RAM_AW+1) bytes of the P2 window; legal range 8..13.
- NUM_BANKS, 1: number of bank registers; legal range 1..4.
- BANK_W, 24: width of P2_ADDR; legal range 21..24.
- CLR_FILL, 16'h0000: word written to every RAM location by the clear sequencer.

Ports:
- CLK_24M  in  1  system clock.
- nRESET  in  1  asynchronous, active-low reset.
- M68K_ADDR  in  19  68K address [19:1] within the P2 window.
- M68K_DIN  in  16  CPU write data.
- M68K_DOUT  out  16  registered read data.
- M68K_DOE_L  out  1  drive enable for DOUT[7:0]; equals ENABLE & ~nPORTOEL.
- M68K_DOE_U  out  1  drive enable for DOUT[15:8]; equals ENABLE & ~nPORTOEU.
- PROM_DATA  in  16  P2 PROM data.
- nPORTOEL, nPORTOEU  in  1 each  byte read strobes, active-low.
- nPORTWEL, nPORTWEU  in  1 each  byte write strobes, active-low, asynchronous to CLK_24M.
- ENABLE  in  1  cart uses this chip.
- P2_ADDR  out  BANK_W  PROM byte address.
- BUSY  out  1  clear sequencer active.

Behaviour:
- Reset: the following clear asynchronously.
  - Bank registers 0, bank select 0, colour regs (ur, ug, ub, us) 0, pcol 0.
  - DOUT 0, BUSY 1, strobe synchronisers 1, clear counter 0.
- Write capture:
  - Each nPORTWE* passes through a 2-FF synchroniser; a falling edge is detected on the next stage.
  - M68K_ADDR and M68K_DIN are sampled in the detect cycle; the register updates on the following edge.
  - Strobe fall to register visible: at most 4 clocks.
  - L and U edges detected in the same cycle both apply.
  - All writes are ignored when ENABLE=0.
- Decode:
  - PORT_ACC = &ADDR[19:5]; PORT_NO = ADDR[4:1].
  - RAM_ACC = &ADDR[19:RAM_AW+1].
  - Port region lies inside the RAM region; such writes update both RAM and the port.
- Bank select (port 7):
  - Write L byte: sel <= DIN[1:0], only if value < NUM_BANKS; otherwise sel is unchanged.
  - Read returns {14'b0, sel}.
- Bank k (k < NUM_BANKS), port 8+2k:
  - U write: bank_k[7:0] <= {DIN[15:9], 0}.
  - Read: {bank_k[7:0], 8'hA0}.
- Bank k, port 9+2k:
  - U write: bank_k[23:16] <= {0, DIN[14:8]}.
  - L write: bank_k[15:8] <= DIN[7:0].
  - Read: bank_k[23:8].
- Ports 8..15 belonging to k ≥ NUM_BANKS are unmapped: reads return PROM/RAM data, writes are ignored.
- P2_ADDR:
  - ENABLE=1: (bank_sel + {ADDR, 0}) mod 2^BANK_W, combinational.
  - ENABLE=0: 0.
- Colour ports:
  - Port 0 U write: ub[0]=D12, ug[0]=D13, ur={D11:8, D14}, us=D15.
  - Port 0 L write: ub[4:1]=D3:0, ug[4:1]=D7:4.
  - Port 1 read: {3'b0, ug, 3'b0, ub}.
  - Port 2 read: {7'b0, us, 3'b0, ur}.
  - Port 4 U write: {pcol[13], pcol[7:4]} <= {D8, D12:9}.
  - Port 4 L write: {pcol[12], pcol[3:0]} <= {D0, D4:1}.
  - Port 5 U write: pcol[15] <= D8.
  - Port 5 L write: {pcol[14], pcol[11:8]} <= {D0, D4:1}.
  - Port 6 read: pcol.
- Read path:
  - Priority: mapped port > RAM > PROM_DATA.
  - RAM has a 1-clock synchronous read.
  - DOUT is registered every clock.
  - Latency: ADDR stable to DOUT valid is 2 clocks.
- Clear FSM:
  - HOLD (nRESET low): count=0, BUSY=1.
  - CLEAR: entered on nRESET rising. Write CLR_FILL to RAM[count], count+1 per clock. At count = 2^RAM_AW−1, write, then go to READY. Duration 2^RAM_AW clocks.
  - READY: BUSY=0.
  - nRESET low in any state → HOLD, restart from 0.
  - During CLEAR, CPU RAM writes are dropped and RAM reads return 16'h0000; port writes still apply.

Optional Feature:
- Macro NEO_PVC_COLOUR_PORTS_EN.
- Defined: colour ports 0,1,2,4,5,6 behave as above.
- Undefined: colour registers are not built; ports 0–6 are unmapped (reads fall through to RAM/PROM, writes reach RAM only); port 7 and bank ports are unaffected.

Test Plan:
- Reset release, RAM_AW=12 → BUSY high exactly 4096 clocks. Then read 0x2FE000 → 16'h0000. A write of 16'h1234 to 0x2FE000 during CLEAR is lost.
- NUM_BANKS=2: write U 16'hFF00 to port 8 (addr 0x2FFFF0) and 16'h1234 to port 9 → port 8 reads 16'hFEA0, port 9 reads 16'h1234. P2_ADDR at ADDR 0 = 24'h1234FE.
- Bank select: write port 7 = 1 → P2_ADDR follows bank_1. Write port 7 = 3 with NUM_BANKS=2 → sel stays 1.
- Port 0 write 16'hFFFF → port 1 reads 16'h1F1F, port 2 reads 16'h011F.
- Port 4 write 16'h1F1F, port 5 write 16'h0101 → port 6 reads 16'hF0FF.
- Assert nRESET mid-CLEAR at count 100 → BUSY stays high, counter restarts. After release, a full 4096-clock CLEAR runs.

Source files
------------

// File: rtl/neo_pvc_gen2_if.sv
// 68K port-bus / P2 PROM bundle for neo_pvc_gen2; the chip attaches through the slave modport.
interface neo_pvc_gen2_if #(
    parameter int BANK_W = 24
);
    logic [19:1]       M68K_ADDR;
    logic [15:0]       M68K_DIN;
    logic [15:0]       M68K_DOUT;
    logic              M68K_DOE_L;
    logic              M68K_DOE_U;
    logic [15:0]       PROM_DATA;
    logic              nPORTOEL;
    logic              nPORTOEU;
    logic              nPORTWEL;
    logic              nPORTWEU;
    logic              ENABLE;
    logic [BANK_W-1:0] P2_ADDR;
    logic              BUSY;

    modport slave (
        input  M68K_ADDR, M68K_DIN, PROM_DATA,
        input  nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU, ENABLE,
        output M68K_DOUT, M68K_DOE_L, M68K_DOE_U, P2_ADDR, BUSY
    );

    modport master (
        output M68K_ADDR, M68K_DIN, PROM_DATA,
        output nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU, ENABLE,
        input  M68K_DOUT, M68K_DOE_L, M68K_DOE_U, P2_ADDR, BUSY
    );
endinterface

// File: rtl/neo_pvc_gen2.sv
// NEO-PVC-class P2 banking/protection controller with work RAM and post-reset clear.
// Colour pack/unpack ports are built only when NEO_PVC_COLOUR_PORTS_EN is defined.
module neo_pvc_gen2 #(
    parameter int          RAM_AW    = 12,
    parameter int          NUM_BANKS = 1,
    parameter int          BANK_W    = 24,
    parameter logic [15:0] CLR_FILL  = 16'h0000
) (
    input logic           CLK_24M,
    input logic           nRESET,
    neo_pvc_gen2_if.slave bus
);
    localparam int RAM_WORDS = 1 << RAM_AW;

    typedef enum logic [1:0] {HOLD, CLEAR, READY} clr_state_t;

    clr_state_t        clr_state_q;
    logic [RAM_AW-1:0] clr_cnt_q;
    logic              busy_q;

    logic [2:0]  wel_sync_q, weu_sync_q;
    logic        wr_l_q, wr_u_q;
    logic [19:1] wr_addr_q;
    logic [15:0] wr_din_q;
    logic        fall_l, fall_u;

    logic [1:0]  sel_q;
    logic [23:0] bank_q [4];

`ifdef NEO_PVC_COLOUR_PORTS_EN
    logic [4:0]  ur_q, ug_q, ub_q;
    logic        us_q;
    logic [15:0] pcol_q;
`endif

    logic [15:0]       ram_q [RAM_WORDS];
    logic [15:0]       ram_rd_q;
    logic              clearing;
    logic              ram_we_l, ram_we_u;
    logic [RAM_AW-1:0] ram_wa;
    logic [15:0]       ram_wd;

    logic [19:1] rd_addr_q;
    logic [15:0] dout_q, dout_d;
    logic        port_hit, rd_ram;
    logic [15:0] port_val;

    logic        wr_port, wr_ram;
    logic [3:0]  wr_no, rd_no;

    assign wr_port = &wr_addr_q[19:5];
    assign wr_no   = wr_addr_q[4:1];
    assign wr_ram  = &wr_addr_q[19:RAM_AW+1];
    assign rd_no   = rd_addr_q[4:1];

    // Falling edge is seen between the second and third synchroniser stages.
    assign fall_l = wel_sync_q[2] & ~wel_sync_q[1];
    assign fall_u = weu_sync_q[2] & ~weu_sync_q[1];

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            wel_sync_q <= '1;
            weu_sync_q <= '1;
            wr_l_q     <= 1'b0;
            wr_u_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_din_q   <= '0;
        end else begin
            wel_sync_q <= {wel_sync_q[1:0], bus.nPORTWEL};
            weu_sync_q <= {weu_sync_q[1:0], bus.nPORTWEU};
            wr_l_q     <= fall_l & bus.ENABLE;
            wr_u_q     <= fall_u & bus.ENABLE;
            if (fall_l || fall_u) begin
                wr_addr_q <= bus.M68K_ADDR;
                wr_din_q  <= bus.M68K_DIN;
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            sel_q <= '0;
            for (int unsigned k = 0; k < 4; k++) bank_q[k] <= '0;
`ifdef NEO_PVC_COLOUR_PORTS_EN
            ur_q   <= '0;
            ug_q   <= '0;
            ub_q   <= '0;
            us_q   <= 1'b0;
            pcol_q <= '0;
`endif
        end else if (wr_port) begin
            if (wr_l_q && wr_no == 4'd7 && int'(wr_din_q[1:0]) < NUM_BANKS)
                sel_q <= wr_din_q[1:0];
            for (int unsigned k = 0; k < 4; k++) begin
                if (int'(k) < NUM_BANKS) begin
                    if (wr_u_q && wr_no == 4'(8 + 2 * k))
                        bank_q[k][7:0] <= {wr_din_q[15:9], 1'b0};
                    if (wr_no == 4'(9 + 2 * k)) begin
                        if (wr_u_q) bank_q[k][23:16] <= {1'b0, wr_din_q[14:8]};
                        if (wr_l_q) bank_q[k][15:8]  <= wr_din_q[7:0];
                    end
                end
            end
`ifdef NEO_PVC_COLOUR_PORTS_EN
            if (wr_no == 4'd0) begin
                if (wr_u_q) begin
                    ub_q[0] <= wr_din_q[12];
                    ug_q[0] <= wr_din_q[13];
                    ur_q    <= {wr_din_q[11:8], wr_din_q[14]};
                    us_q    <= wr_din_q[15];
                end
                if (wr_l_q) begin
                    ub_q[4:1] <= wr_din_q[3:0];
                    ug_q[4:1] <= wr_din_q[7:4];
                end
            end
            if (wr_no == 4'd4) begin
                if (wr_u_q) {pcol_q[13], pcol_q[7:4]} <= {wr_din_q[8], wr_din_q[12:9]};
                if (wr_l_q) {pcol_q[12], pcol_q[3:0]} <= {wr_din_q[0], wr_din_q[4:1]};
            end
            if (wr_no == 4'd5) begin
                if (wr_u_q) pcol_q[15] <= wr_din_q[8];
                if (wr_l_q) {pcol_q[14], pcol_q[11:8]} <= {wr_din_q[0], wr_din_q[4:1]};
            end
`endif
        end
    end

    // HOLD only survives a clock edge once nRESET is high, so it already clears word 0.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            clr_state_q <= HOLD;
            clr_cnt_q   <= '0;
            busy_q      <= 1'b1;
        end else begin
            unique case (clr_state_q)
                HOLD, CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        clr_state_q <= READY;
                        busy_q      <= 1'b0;
                    end else begin
                        clr_state_q <= CLEAR;
                    end
                end
                default: clr_state_q <= READY;
            endcase
        end
    end

    always_comb begin
        clearing = (clr_state_q != READY);
        ram_wa   = clearing ? clr_cnt_q : wr_addr_q[RAM_AW:1];
        ram_wd   = clearing ? CLR_FILL : wr_din_q;
        ram_we_l = clearing | (wr_ram & wr_l_q);
        ram_we_u = clearing | (wr_ram & wr_u_q);
    end

    always_ff @(posedge CLK_24M) begin
        if (ram_we_l) ram_q[ram_wa][7:0]  <= ram_wd[7:0];
        if (ram_we_u) ram_q[ram_wa][15:8] <= ram_wd[15:8];
        ram_rd_q <= ram_q[bus.M68K_ADDR[RAM_AW:1]];
    end

    always_comb begin
        port_hit = 1'b0;
        port_val = '0;
        if (&rd_addr_q[19:5]) begin
            if (rd_no == 4'd7) begin
                port_hit = 1'b1;
                port_val = {14'b0, sel_q};
            end else if (rd_no[3] && int'(rd_no[2:1]) < NUM_BANKS) begin
                port_hit = 1'b1;
                port_val = rd_no[0] ? bank_q[rd_no[2:1]][23:8]
                                    : {bank_q[rd_no[2:1]][7:0], 8'hA0};
`ifdef NEO_PVC_COLOUR_PORTS_EN
            end else if (rd_no == 4'd1) begin
                port_hit = 1'b1;
                port_val = {3'b0, ug_q, 3'b0, ub_q};
            end else if (rd_no == 4'd2) begin
                port_hit = 1'b1;
                port_val = {7'b0, us_q, 3'b0, ur_q};
            end else if (rd_no == 4'd6) begin
                port_hit = 1'b1;
                port_val = pcol_q;
`endif
            end
        end
        rd_ram = &rd_addr_q[19:RAM_AW+1];
        dout_d = port_hit ? port_val
               : rd_ram   ? (busy_q ? 16'h0000 : ram_rd_q)
               :            bus.PROM_DATA;
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            rd_addr_q <= '0;
            dout_q    <= '0;
        end else begin
            rd_addr_q <= bus.M68K_ADDR;
            dout_q    <= dout_d;
        end
    end

    assign bus.M68K_DOUT  = dout_q;
    assign bus.M68K_DOE_L = bus.ENABLE & ~bus.nPORTOEL;
    assign bus.M68K_DOE_U = bus.ENABLE & ~bus.nPORTOEU;
    assign bus.BUSY       = busy_q;
    assign bus.P2_ADDR    = bus.ENABLE
                          ? bank_q[sel_q][BANK_W-1:0] + BANK_W'({bus.M68K_ADDR, 1'b0})
                          : '0;
endmodule

// File: tb/tb_neo_pvc_gen2.sv
// Randomised bench for neo_pvc_gen2 against a transaction-level model of ports, banks and RAM.
module tb_neo_pvc_gen2;
    localparam int          RAM_AW    = 12;
    localparam int          NB        = 2;
    localparam int          BW        = 24;
    localparam logic [15:0] FILL      = 16'h0000;
    localparam int          RAM_WORDS = 1 << RAM_AW;
    localparam int          RAM_BASE  = (1 << 19) - RAM_WORDS;
    localparam int          PORT_BASE = (1 << 19) - 16;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    neo_pvc_gen2_if #(.BANK_W(BW)) bus ();

    neo_pvc_gen2 #(
        .RAM_AW   (RAM_AW),
        .NUM_BANKS(NB),
        .BANK_W   (BW),
        .CLR_FILL (FILL)
    ) dut (
        .CLK_24M(clk),
        .nRESET (nrst),
        .bus    (bus.slave)
    );

    always #21 clk = ~clk;

    logic [15:0] m_ram [RAM_WORDS];
    logic [23:0] m_bank [4];
    int          m_sel;
    bit          m_busy;
`ifdef NEO_PVC_COLOUR_PORTS_EN
    logic [4:0]  m_ur, m_ug, m_ub;
    logic        m_us;
    logic [15:0] m_pcol;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sel  = 0;
        m_busy = 1'b1;
        foreach (m_bank[k]) m_bank[k] = '0;
        foreach (m_ram[i]) m_ram[i] = FILL;
`ifdef NEO_PVC_COLOUR_PORTS_EN
        m_ur = '0; m_ug = '0; m_ub = '0; m_us = 1'b0; m_pcol = '0;
`endif
    endtask

    function automatic logic [15:0] exp_read(input int a, input logic [15:0] prom);
        int pn, k;
        if (a >= PORT_BASE) begin
            pn = a - PORT_BASE;
            if (pn == 7) return 16'(m_sel);
            if (pn >= 8) begin
                k = (pn - 8) / 2;
                if (k < NB) return (pn % 2 == 1) ? m_bank[k][23:8] : {m_bank[k][7:0], 8'hA0};
            end
`ifdef NEO_PVC_COLOUR_PORTS_EN
            if (pn == 1) return {3'b0, m_ug, 3'b0, m_ub};
            if (pn == 2) return {7'b0, m_us, 3'b0, m_ur};
            if (pn == 6) return m_pcol;
`endif
        end
        if (a >= RAM_BASE) return m_busy ? 16'h0000 : m_ram[a - RAM_BASE];
        return prom;
    endfunction

    task automatic model_write(input int a, input logic [15:0] d, input bit l, input bit u);
        int pn, k;
        logic [15:0] w;
        if (bus.ENABLE !== 1'b1) return;
        if (a >= RAM_BASE && !m_busy) begin
            w = m_ram[a - RAM_BASE];
            if (l) w[7:0]  = d[7:0];
            if (u) w[15:8] = d[15:8];
            m_ram[a - RAM_BASE] = w;
        end
        if (a < PORT_BASE) return;
        pn = a - PORT_BASE;
        if (pn == 7 && l && int'(d[1:0]) < NB) m_sel = int'(d[1:0]);
        if (pn >= 8) begin
            k = (pn - 8) / 2;
            if (k < NB) begin
                if (pn % 2 == 0) begin
                    if (u) m_bank[k][7:0] = {d[15:9], 1'b0};
                end else begin
                    if (u) m_bank[k][23:16] = {1'b0, d[14:8]};
                    if (l) m_bank[k][15:8]  = d[7:0];
                end
            end
        end
`ifdef NEO_PVC_COLOUR_PORTS_EN
        if (pn == 0) begin
            if (u) begin m_ub[0] = d[12]; m_ug[0] = d[13]; m_ur = {d[11:8], d[14]}; m_us = d[15]; end
            if (l) begin m_ub[4:1] = d[3:0]; m_ug[4:1] = d[7:4]; end
        end
        if (pn == 4) begin
            if (u) begin m_pcol[13] = d[8]; m_pcol[7:4] = d[12:9]; end
            if (l) begin m_pcol[12] = d[0]; m_pcol[3:0] = d[4:1]; end
        end
        if (pn == 5) begin
            if (u) m_pcol[15] = d[8];
            if (l) begin m_pcol[14] = d[0]; m_pcol[11:8] = d[4:1]; end
        end
`endif
    endtask

    task automatic cpu_write(input int a, input logic [15:0] d, input bit l, input bit u);
        @(negedge clk);
        bus.M68K_ADDR = 19'(a);
        bus.M68K_DIN  = d;
        bus.nPORTWEL  = !l;
        bus.nPORTWEU  = !u;
        repeat (6) @(negedge clk);
        bus.nPORTWEL = 1'b1;
        bus.nPORTWEU = 1'b1;
        repeat (4) @(negedge clk);
        model_write(a, d, l, u);
    endtask

    task automatic cpu_read(input int a, input string tag);
        logic [15:0] prom;
        bit oel;
        @(negedge clk);
        prom          = 16'($urandom);
        oel           = bit'($urandom_range(0, 1));
        bus.M68K_ADDR = 19'(a);
        bus.PROM_DATA = prom;
        bus.nPORTOEL  = oel;
        bus.nPORTOEU  = 1'b0;
        #1;
        chk({tag, "_doe"}, 32'({bus.M68K_DOE_U, bus.M68K_DOE_L}),
            32'({bus.ENABLE, bus.ENABLE & ~oel}));
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, 32'(bus.M68K_DOUT), 32'(exp_read(a, prom)));
        bus.nPORTOEL = 1'b1;
        bus.nPORTOEU = 1'b1;
    endtask

    task automatic check_p2(input int a, input string tag);
        longint exp;
        @(negedge clk);
        bus.M68K_ADDR = 19'(a);
        #1;
        exp = (bus.ENABLE === 1'b1)
            ? (longint'(m_bank[m_sel]) + 2 * longint'(a)) % (longint'(1) << BW) : 0;
        chk(tag, 32'(bus.P2_ADDR), 32'(exp));
    endtask

    task automatic wait_clear(input string tag);
        int cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (bus.BUSY === 1'b1 && cycles < 10000);
        chk(tag, 32'(cycles), 32'(RAM_WORDS));
        m_busy = 1'b0;
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 2))
            0:       return PORT_BASE + int'($urandom_range(0, 15));
            1:       return RAM_BASE + int'($urandom_range(0, RAM_WORDS - 1));
            default: return int'($urandom_range(0, (1 << 19) - 1));
        endcase
    endfunction

    initial begin
        nrst          = 1'b0;
        bus.M68K_ADDR = '0;
        bus.M68K_DIN  = '0;
        bus.PROM_DATA = '0;
        bus.nPORTOEL  = 1'b1;
        bus.nPORTOEU  = 1'b1;
        bus.nPORTWEL  = 1'b1;
        bus.nPORTWEU  = 1'b1;
        bus.ENABLE    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.BUSY), 32'd1);
        chk("rst_dout", 32'(bus.M68K_DOUT), 32'd0);
        check_p2(19'h12345, "rst_p2");

        // Clear after reset; a RAM write during it is lost, a port write still lands.
        @(negedge clk);
        nrst = 1'b1;
        fork
            wait_clear("clr_len0");
            begin
                cpu_write(RAM_BASE, 16'h1234, 1'b1, 1'b1);
                cpu_write(PORT_BASE + 7, 16'h0001, 1'b1, 1'b0);
            end
        join
        cpu_read(RAM_BASE, "ram0_lost");
        cpu_read(PORT_BASE + 7, "sel_in_clear");

        cpu_write(PORT_BASE + 8, 16'hFF00, 1'b0, 1'b1);
        cpu_write(PORT_BASE + 9, 16'h1234, 1'b1, 1'b1);
        cpu_read(PORT_BASE + 8, "port8");
        chk("port8_val", 32'(bus.M68K_DOUT), 32'h0000FEA0);
        cpu_read(PORT_BASE + 9, "port9");
        chk("port9_val", 32'(bus.M68K_DOUT), 32'h00001234);
        cpu_write(PORT_BASE + 7, 16'h0000, 1'b1, 1'b0);
        check_p2(0, "p2_bank0");
        chk("p2_bank0_val", 32'(bus.P2_ADDR), 32'h001234FE);
        cpu_write(PORT_BASE + 10, 16'($urandom), 1'b0, 1'b1);
        cpu_write(PORT_BASE + 11, 16'($urandom), 1'b1, 1'b1);
        cpu_write(PORT_BASE + 7, 16'h0001, 1'b1, 1'b0);
        check_p2(rand_addr(), "p2_bank1");
        cpu_write(PORT_BASE + 7, 16'h0003, 1'b1, 1'b0);
        cpu_read(PORT_BASE + 7, "sel_hold");
        check_p2(rand_addr(), "p2_sel_hold");

        cpu_write(PORT_BASE + 0, 16'hFFFF, 1'b1, 1'b1);
        cpu_read(PORT_BASE + 1, "port1");
        cpu_read(PORT_BASE + 2, "port2");
        cpu_write(PORT_BASE + 4, 16'h1F1F, 1'b1, 1'b1);
        cpu_write(PORT_BASE + 5, 16'h0101, 1'b1, 1'b1);
        cpu_read(PORT_BASE + 6, "port6");

        for (int i = 0; i < 120; i++) begin
            int lu;
            bus.ENABLE = ($urandom_range(0, 9) != 0);
            lu = int'($urandom_range(1, 3));
            case ($urandom_range(0, 2))
                0:       cpu_write(rand_addr(), 16'($urandom), lu[0], lu[1]);
                1:       cpu_read(rand_addr(), "rand_rd");
                default: check_p2(rand_addr(), "rand_p2");
            endcase
        end
        bus.ENABLE = 1'b1;

        // Reset during a clear restarts it from word 0 and reads stay masked meanwhile.
        cpu_write(RAM_BASE + 4000, 16'hBEEF, 1'b1, 1'b1);
        cpu_read(RAM_BASE + 4000, "beef");
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (40) @(posedge clk);
        cpu_read(RAM_BASE + 4000, "rd_in_clear");
        repeat (57) @(posedge clk);
        #1;
        chk("busy_mid", 32'(bus.BUSY), 32'd1);
        @(negedge clk);
        nrst = 1'b0;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            chk("busy_hold", 32'(bus.BUSY), 32'd1);
        end
        nrst = 1'b1;
        wait_clear("clr_len1");
        cpu_read(RAM_BASE + 4000, "beef_cleared");
        cpu_read(PORT_BASE + 8, "bank_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
